// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//
// Game-flow controller for the pong datapath. It consumes the per-frame tick
// and the hit/miss events from ball physics. It produces the ball step and
// reload pulses and the paddle enable. It also keeps score, lives and speed
// level.
//
// Optional feature: define PONG_PAUSE_EN to add the pause_btn input and the
// PAUSE state (encoding 5). When the macro is undefined, the port is absent
// and PAUSE is unreachable.
//
// Ports:
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   frame_tick in   one-cycle pulse at the start of each frame
//   start_btn  in   debounced start button (level)
//   pause_btn  in   debounced pause button (level, PONG_PAUSE_EN only)
//   hit_evt    in   one-cycle pulse: ball struck paddle
//   miss_evt   in   one-cycle pulse: ball left the field behind the paddle
//   step_en    out  one-cycle pulse: advance ball one step
//   ball_rst   out  one-cycle pulse: reload ball to centre
//   paddle_en  out  paddle may move (SERVE and PLAY)
//   level      out  speed level 0..MAX_LEVEL
//   score      out  hits scored this game (saturating)
//   lives      out  remaining lives
//   state      out  FSM state encoding
//   game_over  out  high while in OVER
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int SERVE_FRAMES   = 60,
  parameter int LIVES_INIT     = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
`ifdef PONG_PAUSE_EN
  input  logic               pause_btn,
`endif
  input  logic               hit_evt,
  input  logic               miss_evt,
  output logic               step_en,
  output logic               ball_rst,
  output logic               paddle_en,
  output logic [1:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         state,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]         HITS_LAST  = 4'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]         LEVEL_TOP  = 2'(MAX_LEVEL);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = '1;

  state_t             state_reg;
  logic               start_q;
  logic               start_rise;
  logic [7:0]         frame_cnt;
  logic [1:0]         div_cnt;
  // Last divider value before wrap. It is latched only at PLAY entry and at
  // each wrap, so a level change never shortens or stretches a step in flight.
  logic [1:0]         div_max;
  logic [3:0]         hit_cnt;
  logic               div_tick;

  assign start_rise = start_btn & ~start_q;
  assign state      = state_reg;

`ifdef PONG_PAUSE_EN
  logic pause_q;
  logic pause_rise;
  assign pause_rise = pause_btn & ~pause_q;
  // A tick on the cycle that enters PAUSE belongs to the (frozen) pause state.
  assign div_tick   = frame_tick & ~pause_rise;
`else
  assign div_tick   = frame_tick;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      start_q   <= 1'b0;
      step_en   <= 1'b0;
      ball_rst  <= 1'b0;
      paddle_en <= 1'b0;
      level     <= '0;
      score     <= '0;
      lives     <= '0;
      game_over <= 1'b0;
      frame_cnt <= '0;
      div_cnt   <= '0;
      div_max   <= '0;
      hit_cnt   <= '0;
`ifdef PONG_PAUSE_EN
      pause_q   <= 1'b0;
`endif
    end else begin
      start_q  <= start_btn;
`ifdef PONG_PAUSE_EN
      pause_q  <= pause_btn;
`endif
      step_en  <= 1'b0;
      ball_rst <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state_reg <= ST_SERVE;
            score     <= '0;
            lives     <= LIVES_LOAD;
            level     <= '0;
            hit_cnt   <= '0;
            frame_cnt <= '0;
            ball_rst  <= 1'b1;
            paddle_en <= 1'b1;
            game_over <= 1'b0;
          end
        end

        ST_SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              state_reg <= ST_PLAY;
              div_cnt   <= '0;
              div_max   <= 2'd3 - level;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        ST_PLAY: begin
          // A miss ends the rally; a coincident hit or tick is discarded.
          if (miss_evt) begin
            state_reg <= ST_MISS;
            paddle_en <= 1'b0;
          end else begin
`ifdef PONG_PAUSE_EN
            if (pause_rise) begin
              state_reg <= ST_PAUSE;
              paddle_en <= 1'b0;
            end
`endif
            if (div_tick) begin
              if (div_cnt == div_max) begin
                div_cnt <= '0;
                div_max <= 2'd3 - level;
                step_en <= 1'b1;
              end else begin
                div_cnt <= div_cnt + 2'd1;
              end
            end
            if (hit_evt) begin
              if (score != SCORE_TOP) score <= score + 1'b1;
              if (hit_cnt == HITS_LAST) begin
                hit_cnt <= '0;
                if (level != LEVEL_TOP) level <= level + 2'd1;
              end else begin
                hit_cnt <= hit_cnt + 4'd1;
              end
            end
          end
        end

        ST_MISS: begin
          if (lives == 2'd1) begin
            lives     <= '0;
            state_reg <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            lives     <= lives - 2'd1;
            state_reg <= ST_SERVE;
            frame_cnt <= '0;
            ball_rst  <= 1'b1;
            paddle_en <= 1'b1;
          end
        end

`ifdef PONG_PAUSE_EN
        ST_PAUSE: begin
          if (pause_rise) begin
            state_reg <= ST_PLAY;
            paddle_en <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg <= ST_IDLE;
          paddle_en <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//
// Random stimulus drives the controller. A game-rules reference model predicts
// every output for every clock and pushes the prediction into a queue. A
// monitor pops one prediction per clock and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

  localparam int SERVE_FRAMES   = 60;
  localparam int LIVES_INIT     = 3;
  localparam int HITS_PER_LEVEL = 4;
  localparam int MAX_LEVEL      = 3;
  localparam int SCORE_W        = 8;
  localparam int SCORE_MAX      = (1 << SCORE_W) - 1;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_MISS  = 3;
  localparam int S_OVER  = 4;
  localparam int S_PAUSE = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_tick = 1'b0;
  logic               start_btn = 1'b0;
  logic               hit_evt = 1'b0;
  logic               miss_evt = 1'b0;
`ifdef PONG_PAUSE_EN
  logic               pause_btn = 1'b0;
`endif
  logic               step_en;
  logic               ball_rst;
  logic               paddle_en;
  logic [1:0]         level;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic [2:0]         state;
  logic               game_over;

  always #20 clk = ~clk;

  pong_game_ctrl #(
    .SERVE_FRAMES  (SERVE_FRAMES),
    .LIVES_INIT    (LIVES_INIT),
    .HITS_PER_LEVEL(HITS_PER_LEVEL),
    .MAX_LEVEL     (MAX_LEVEL),
    .SCORE_W       (SCORE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .start_btn (start_btn),
`ifdef PONG_PAUSE_EN
    .pause_btn (pause_btn),
`endif
    .hit_evt   (hit_evt),
    .miss_evt  (miss_evt),
    .step_en   (step_en),
    .ball_rst  (ball_rst),
    .paddle_en (paddle_en),
    .level     (level),
    .score     (score),
    .lives     (lives),
    .state     (state),
    .game_over (game_over)
  );

  typedef struct {
    int st;
    int step;
    int brst;
    int pad;
    int lvl;
    int scr;
    int liv;
    int over;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_steps  = 0;
  int   n_overs  = 0;
  bit   rst_req  = 1'b0;

  // ---------------- reference model: game rules ----------------
  int m_mode, m_lives, m_score, m_level, m_hits;
  int m_serve_ticks;  // ticks seen since the serve started
  int m_div;          // ticks since the last ball step
  int m_period;       // frames per step, fixed at PLAY entry and at each step
  int m_step, m_brst;
  bit m_start_q, m_pause_q;

  function automatic void model_reset();
    m_mode = S_IDLE; m_lives = 0; m_score = 0; m_level = 0; m_hits = 0;
    m_serve_ticks = 0; m_div = 0; m_period = 4;
    m_step = 0; m_brst = 0; m_start_q = 1'b0; m_pause_q = 1'b0;
  endfunction

  function automatic void model_step(bit t, bit s, bit h, bit m, bit p);
    bit rise  = s && !m_start_q;
    bit prise = p && !m_pause_q;
    m_start_q = s;
    m_pause_q = p;
    m_step = 0;
    m_brst = 0;
    case (m_mode)
      S_IDLE, S_OVER: if (rise) begin
        m_mode = S_SERVE; m_score = 0; m_lives = LIVES_INIT; m_level = 0;
        m_hits = 0; m_serve_ticks = 0; m_brst = 1;
      end
      S_SERVE: if (t) begin
        m_serve_ticks++;
        if (m_serve_ticks == SERVE_FRAMES) begin
          m_mode = S_PLAY; m_div = 0; m_period = 4 - m_level;
        end
      end
      S_PLAY: begin
        if (m) begin
          m_mode = S_MISS;
        end else begin
          if (prise) begin
            m_mode = S_PAUSE;
          end else if (t) begin
            m_div++;
            if (m_div == m_period) begin
              m_step = 1; m_div = 0; m_period = 4 - m_level;
            end
          end
          if (h) begin
            m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
            m_hits++;
            if (m_hits == HITS_PER_LEVEL) begin
              m_hits = 0;
              m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
            end
          end
        end
      end
      S_MISS: begin
        m_lives--;
        if (m_lives == 0) m_mode = S_OVER;
        else begin
          m_mode = S_SERVE; m_serve_ticks = 0; m_brst = 1;
        end
      end
      S_PAUSE: if (prise) m_mode = S_PLAY;
      default: m_mode = S_IDLE;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st   = m_mode;
    e.step = m_step;
    e.brst = m_brst;
    e.pad  = (m_mode == S_SERVE || m_mode == S_PLAY) ? 1 : 0;
    e.lvl  = m_level;
    e.scr  = m_score;
    e.liv  = m_lives;
    e.over = (m_mode == S_OVER) ? 1 : 0;
    return e;
  endfunction

  // ---------------- comparison ----------------
  task automatic check_out(input string name, input exp_t e);
    exp_t a;
    a.st = int'(state); a.step = int'(step_en); a.brst = int'(ball_rst);
    a.pad = int'(paddle_en); a.lvl = int'(level); a.scr = int'(score);
    a.liv = int'(lives); a.over = int'(game_over);
    n_checks++;
    if (a != e || (step_en && ball_rst)) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d step=%0d brst=%0d pad=%0d lvl=%0d score=%0d lives=%0d over=%0d, expected st=%0d step=%0d brst=%0d pad=%0d lvl=%0d score=%0d lives=%0d over=%0d",
               name, $time, a.st, a.step, a.brst, a.pad, a.lvl, a.scr, a.liv, a.over,
               e.st, e.step, e.brst, e.pad, e.lvl, e.scr, e.liv, e.over);
    end
  endtask

  // Monitor: the DUT presents a new output set on every clock.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (step_en) n_steps++;
      if (game_over && e.over == 1) n_overs++;
      check_out("outputs", e);
    end
  end

  // ---------------- stimulus ----------------
  // Percent chances: tick, hit, miss, start-button toggle.
  task automatic cycle(input int p_tick, input int p_hit, input int p_miss, input int p_tog);
    bit p = 1'b0;
    @(negedge clk);
    rst_n      = rst_req;
    frame_tick = ($urandom_range(99) < p_tick);
    hit_evt    = ($urandom_range(99) < p_hit);
    miss_evt   = ($urandom_range(99) < p_miss);
    if ($urandom_range(99) < p_tog) start_btn = ~start_btn;
`ifdef PONG_PAUSE_EN
    if ($urandom_range(99) < 2) pause_btn = ~pause_btn;
    p = pause_btn;
`endif
    if (!rst_n) model_reset();
    else model_step(frame_tick, start_btn, hit_evt, miss_evt, p);
    exp_q.push_back(model_out());
  endtask

  // Asynchronous reset: outputs must clear before the next clock edge.
  task automatic async_reset();
    @(negedge clk);
    rst_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_out("async_reset", model_out());
    exp_q.push_back(model_out());
  endtask

  initial begin
    model_reset();
    // Start held through reset release must produce a rise on the first clock.
    start_btn = 1'b1;
    rst_req   = 1'b0;
    repeat (3) cycle(0, 0, 0, 0);
    rst_req = 1'b1;
    repeat (400) cycle(30, 0, 0, 0);       // serve, then plain play at level 0
    repeat (1500) cycle(30, 35, 0, 0);     // level and score saturation
    cycle(30, 100, 100, 0);                // hit and miss together
    repeat (4000) cycle(30, 10, 1, 2);     // full games, game over, restarts
    async_reset();
    repeat (4) cycle(30, 10, 1, 2);
    rst_req = 1'b1;
    repeat (2500) cycle(30, 10, 1, 3);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    n_checks++;
    if (n_steps == 0 || n_overs == 0) begin
      n_fail++;
      $display("FAIL coverage: got steps=%0d over_cycles=%0d, expected both nonzero", n_steps, n_overs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow controller that sequences the pong ball/paddle datapath. It consumes the per-frame tick from VGA timing and hit/miss events from ball physics. It produces ball step enables, ball reload pulses and paddle enable, and keeps score, lives and speed level. It sits between the VGA timing counters and the ball/paddle update logic in the top module.

Parameters:
SERVE_FRAMES, 60, frame ticks spent in SERVE before play (1..255)
LIVES_INIT, 3, lives at start of a game (1..3)
HITS_PER_LEVEL, 4, paddle hits needed per speed-level increment (1..15)
MAX_LEVEL, 3, highest speed level (0..3)
SCORE_W, 8, score counter width

Ports:
clk  in  1  pixel clock, 25 MHz
rst_n  in  1  reset, asynchronous, active-low
frame_tick  in  1  one-cycle pulse at h_count==0 && v_count==0
start_btn  in  1  debounced start button, level, active-high
hit_evt  in  1  one-cycle pulse: ball struck paddle
miss_evt  in  1  one-cycle pulse: ball left field behind paddle
step_en  out  1  one-cycle pulse: physics advances ball one step
ball_rst  out  1  one-cycle pulse: physics reloads ball to centre, default velocity
paddle_en  out  1  level: paddle may move
level  out  2  current speed level 0..MAX_LEVEL
score  out  SCORE_W  hits scored this game
lives  out  2  remaining lives
state  out  3  FSM state encoding
game_over  out  1  high while in OVER

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low. Reset values: state=IDLE, step_en=0, ball_rst=0, paddle_en=0, level=0, score=0, lives=0, game_over=0, internal counters=0, start_q=0.
- start_rise = start_btn & ~start_q. start_q is registered every cycle. A button held through reset release yields a rise on the first clock.
- State encoding: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, PAUSE=5 (PAUSE only with the optional feature).
- IDLE: on start_rise go to SERVE. Same edge loads score=0, lives=LIVES_INIT, level=0, hit_cnt=0 and pulses ball_rst next cycle.
- SERVE: ball held. Count frame_tick. On the SERVE_FRAMES-th tick go to PLAY and clear the step divider.
- PLAY:
  - paddle_en=1.
  - Step divider counts frame_ticks, modulo (4 - level): 4/3/2/1 frames per step at levels 0..3.
  - step_en pulses the cycle after the frame_tick on which the divider wraps to 0. The first step comes on the (4-level)-th tick after entry.
- paddle_en is 1 in SERVE and PLAY and 0 elsewhere. It updates with the state register.
- Hit in PLAY:
  - score += 1, saturating at 2^SCORE_W-1.
  - hit_cnt += 1. When hit_cnt reaches HITS_PER_LEVEL, it clears and level += 1, saturating at MAX_LEVEL. At MAX_LEVEL hit_cnt still clears.
  - A level change takes effect at the next divider wrap, not mid-count.
- Miss in PLAY: go to MISS. If hit_evt and miss_evt are asserted in the same cycle, miss wins and the hit is discarded.
- MISS lasts exactly one cycle. Decrement lives.
  - If lives was 1, go to OVER (lives=0).
  - Otherwise go to SERVE with a ball_rst pulse. Level and score are kept.
- OVER: game_over=1; ball frozen; step_en never asserted. On start_rise, behave as the IDLE start.
- hit_evt and miss_evt are ignored outside PLAY.
- frame_tick coinciding with a state transition counts only toward the destination state's counter (counters clear on entry).
- Reset mid-game returns to IDLE immediately with all reset values. No ball_rst is issued by reset itself.
- ball_rst is never asserted in the same cycle as step_en.

Optional Feature:
PONG_PAUSE_EN.
- Defined:
  - Adds input port pause_btn (1 bit, debounced, active-high), with its own rising-edge detector.
  - A rise in PLAY goes to PAUSE. A rise in PAUSE returns to PLAY.
  - In PAUSE: step_en=0, paddle_en=0, hit/miss ignored, step divider frozen (resumes from held value).
  - start_rise in PAUSE is ignored.
- Undefined: port absent, PAUSE unreachable, encoding 5 unused.

Test Plan:
1. Reset, then start_btn 0->1 -> ball_rst pulse 1 cycle later; state=SERVE, lives=3, score=0, level=0. After 60 frame_ticks -> state=PLAY, paddle_en=1.
2. In PLAY at level 0, 12 frame_ticks -> exactly 3 step_en pulses, each one cycle after ticks 4, 8, 12.
3. 4 hit_evt pulses -> score=4, level=1, then steps every 3 frames. 12 further hits -> level=3 (saturated), score=16, step every frame.
4. hit_evt and miss_evt in the same cycle with lives=3 -> score unchanged, MISS for 1 cycle, lives=2, ball_rst pulse, state=SERVE.
5. Three misses from a fresh game -> lives=0, state=OVER, game_over=1, no step_en over 10 frame_ticks. start_btn rise -> new game with lives=3, score=0.
6. With PONG_PAUSE_EN, pause_btn rise mid-divider (2 of 4 ticks) -> PAUSE, no step_en for 20 ticks. Second rise -> PLAY, first step_en after 2 more ticks.
